// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch (IF) and data load/store (D).
// One transaction in flight; D has fixed priority, bounded by a starvation counter
// that forces an IF grant after STARVE_LIMIT consecutive D grants while IF waits.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned TIMEOUT      = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req_valid,
  output logic              if_req_ready,
  input  logic [ADDR_W-1:0] if_req_addr,
  output logic              if_rsp_valid,
  output logic [DATA_W-1:0] if_rsp_data,
  input  logic              d_req_valid,
  output logic              d_req_ready,
  input  logic [ADDR_W-1:0] d_req_addr,
  input  logic              d_req_we,
  input  logic [DATA_W-1:0] d_req_wdata,
  output logic              d_rsp_valid,
  output logic [DATA_W-1:0] d_rsp_data,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_rsp_valid,
  input  logic [DATA_W-1:0] mem_rsp_data,
  output logic              err_timeout
);

  localparam int unsigned SC_W  = $clog2(STARVE_LIMIT + 1);
  localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ISSUE    = 2'd1,
    WAIT_RSP = 2'd2
  } state_t;

  state_t            state;
  logic [SC_W-1:0]   starve_cnt;
  logic [TMO_W-1:0]  tmo_cnt;
  logic              owner_d;
  logic              starve_hit_c;
  logic              grant_d_c;
  logic              grant_if_c;

  // Arbitration: ready goes combinationally to the winner, only while idle
  assign starve_hit_c = (starve_cnt == SC_W'(STARVE_LIMIT));
  assign grant_d_c    = (state == IDLE) && d_req_valid && !(if_req_valid && starve_hit_c);
  assign grant_if_c   = (state == IDLE) && if_req_valid && !grant_d_c;
  assign d_req_ready  = grant_d_c;
  assign if_req_ready = grant_if_c;

  // Transaction FSM with registered memory-side and response-side outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      starve_cnt    <= '0;
      tmo_cnt       <= '0;
      owner_d       <= 1'b0;
      mem_req_valid <= 1'b0;
      mem_addr      <= '0;
      mem_we        <= 1'b0;
      mem_wdata     <= '0;
      if_rsp_valid  <= 1'b0;
      if_rsp_data   <= '0;
      d_rsp_valid   <= 1'b0;
      d_rsp_data    <= '0;
      err_timeout   <= 1'b0;
    end else begin
      if_rsp_valid <= 1'b0;
      d_rsp_valid  <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_d_c) begin
            mem_addr      <= d_req_addr;
            mem_we        <= d_req_we;
            mem_wdata     <= d_req_wdata;
            owner_d       <= 1'b1;
            mem_req_valid <= 1'b1;
            state         <= ISSUE;
            if (!if_req_valid) begin
              starve_cnt <= '0;
            end else if (!starve_hit_c) begin
              starve_cnt <= starve_cnt + SC_W'(1);
            end
          end else if (grant_if_c) begin
            mem_addr      <= if_req_addr;
            mem_we        <= 1'b0;
            mem_wdata     <= '0;
            owner_d       <= 1'b0;
            mem_req_valid <= 1'b1;
            state         <= ISSUE;
            starve_cnt    <= '0;
          end
        end
        ISSUE: begin
          if (mem_req_ready) begin
            mem_req_valid <= 1'b0;
            tmo_cnt       <= '0;
            state         <= WAIT_RSP;
          end
        end
        WAIT_RSP: begin
          // A response on the timeout cycle still counts as a normal completion
          if (mem_rsp_valid) begin
            if (owner_d) begin
              d_rsp_valid <= 1'b1;
              d_rsp_data  <= mem_we ? '0 : mem_rsp_data;
            end else begin
              if_rsp_valid <= 1'b1;
              if_rsp_data  <= mem_rsp_data;
            end
            state <= IDLE;
          end else if (tmo_cnt == TMO_W'(TIMEOUT - 1)) begin
            err_timeout <= 1'b1;
            if (owner_d) begin
              d_rsp_valid <= 1'b1;
              d_rsp_data  <= '0;
            end else begin
              if_rsp_valid <= 1'b1;
              if_rsp_data  <= '0;
            end
            state <= IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter (STARVE_LIMIT=4, TIMEOUT=8).
module tb_mem_port_arbiter;

  logic        clk;
  logic        reset;
  logic        if_req_valid;
  logic        if_req_ready;
  logic [31:0] if_req_addr;
  logic        if_rsp_valid;
  logic [31:0] if_rsp_data;
  logic        d_req_valid;
  logic        d_req_ready;
  logic [31:0] d_req_addr;
  logic        d_req_we;
  logic [31:0] d_req_wdata;
  logic        d_rsp_valid;
  logic [31:0] d_rsp_data;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_addr;
  logic        mem_we;
  logic [31:0] mem_wdata;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;
  logic        err_timeout;

  int checks   = 0;
  int failures = 0;

  mem_port_arbiter #(
    .ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(4), .TIMEOUT(8)
  ) dut (
    .clk(clk), .reset(reset),
    .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_req_addr(if_req_addr),
    .if_rsp_valid(if_rsp_valid), .if_rsp_data(if_rsp_data),
    .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_req_addr(d_req_addr),
    .d_req_we(d_req_we), .d_req_wdata(d_req_wdata),
    .d_rsp_valid(d_rsp_valid), .d_rsp_data(d_rsp_data),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
    .err_timeout(err_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One zero-wait transaction starting in an IDLE cycle; reports which side got ready
  task automatic xact(input logic [31:0] rdata, output logic gi, output logic gd);
    #1;
    gi = if_req_ready;
    gd = d_req_ready;
    tick();
    tick();
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = rdata;
    tick();
    mem_rsp_valid = 1'b0;
  endtask

  logic [1:0] exp_grant [10] = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10,
                                 2'b01, 2'b01, 2'b01, 2'b01, 2'b10};

  initial begin
    logic gi, gd;
    logic [31:0] rd;

    reset = 1'b1;
    if_req_valid = 1'b0; if_req_addr = '0;
    d_req_valid = 1'b0; d_req_addr = '0; d_req_we = 1'b0; d_req_wdata = '0;
    mem_req_ready = 1'b1; mem_rsp_valid = 1'b0; mem_rsp_data = '0;
    tick();
    tick();
    chk("rst_mem_req_valid", 32'(mem_req_valid), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_if_rsp_valid", 32'(if_rsp_valid), 32'd0);
    chk("rst_d_rsp_valid", 32'(d_rsp_valid), 32'd0);
    chk("rst_err_timeout", 32'(err_timeout), 32'd0);
    reset = 1'b0;
    tick();

    // 1: IF only, zero-wait memory
    if_req_valid = 1'b1; if_req_addr = 32'h10;
    #1;
    chk("t1_if_ready", 32'(if_req_ready), 32'd1);
    chk("t1_d_ready", 32'(d_req_ready), 32'd0);
    tick();
    if_req_valid = 1'b0;
    chk("t1_mem_req_valid", 32'(mem_req_valid), 32'd1);
    chk("t1_mem_addr", mem_addr, 32'h10);
    chk("t1_mem_we", 32'(mem_we), 32'd0);
    tick();
    chk("t1_mem_req_dropped", 32'(mem_req_valid), 32'd0);
    mem_rsp_valid = 1'b1; mem_rsp_data = 32'hDEADBEEF;
    tick();
    mem_rsp_valid = 1'b0;
    chk("t1_if_rsp_valid", 32'(if_rsp_valid), 32'd1);
    chk("t1_if_rsp_data", if_rsp_data, 32'hDEADBEEF);
    chk("t1_d_rsp_quiet", 32'(d_rsp_valid), 32'd0);
    tick();
    chk("t1_if_rsp_one_cycle", 32'(if_rsp_valid), 32'd0);

    // 2: simultaneous IF and D store; D wins, then IF is served
    if_req_valid = 1'b1; if_req_addr = 32'h20;
    d_req_valid = 1'b1; d_req_addr = 32'h100; d_req_we = 1'b1; d_req_wdata = 32'h55;
    #1;
    chk("t2_d_ready", 32'(d_req_ready), 32'd1);
    chk("t2_if_ready", 32'(if_req_ready), 32'd0);
    tick();
    d_req_valid = 1'b0; d_req_we = 1'b0;
    #1;
    chk("t2_mem_addr", mem_addr, 32'h100);
    chk("t2_mem_we", 32'(mem_we), 32'd1);
    chk("t2_mem_wdata", mem_wdata, 32'h55);
    chk("t2_if_ready_busy", 32'(if_req_ready), 32'd0);
    tick();
    mem_rsp_valid = 1'b1; mem_rsp_data = 32'h12345678;
    tick();
    mem_rsp_valid = 1'b0;
    #1;
    chk("t2_d_rsp_valid", 32'(d_rsp_valid), 32'd1);
    chk("t2_d_rsp_data_store", d_rsp_data, 32'd0);
    chk("t2_if_rsp_quiet", 32'(if_rsp_valid), 32'd0);
    chk("t2_if_ready_next", 32'(if_req_ready), 32'd1);
    tick();
    if_req_valid = 1'b0;
    chk("t2_if_mem_addr", mem_addr, 32'h20);
    chk("t2_if_mem_we", 32'(mem_we), 32'd0);
    chk("t2_if_mem_wdata", mem_wdata, 32'd0);
    tick();
    mem_rsp_valid = 1'b1; mem_rsp_data = 32'hCAFE0001;
    tick();
    mem_rsp_valid = 1'b0;
    chk("t2_if_rsp_valid", 32'(if_rsp_valid), 32'd1);
    chk("t2_if_rsp_data", if_rsp_data, 32'hCAFE0001);
    tick();

    // 3: starvation limit with both sides continuously requesting
    if_req_valid = 1'b1; if_req_addr = 32'h40;
    d_req_valid = 1'b1; d_req_addr = 32'h140; d_req_we = 1'b0;
    for (int i = 0; i < 10; i++) begin
      rd = 32'hA0000000 + 32'(i);
      xact(rd, gi, gd);
      chk($sformatf("t3_grant_%0d", i), 32'({gi, gd}), 32'(exp_grant[i]));
      chk($sformatf("t3_rsp_side_%0d", i), 32'({if_rsp_valid, d_rsp_valid}), 32'(exp_grant[i]));
      chk($sformatf("t3_rsp_data_%0d", i), exp_grant[i][1] ? if_rsp_data : d_rsp_data, rd);
    end
    if_req_valid = 1'b0; d_req_valid = 1'b0;
    tick();

    // 4: memory stalls request acceptance for 10 cycles
    d_req_valid = 1'b1; d_req_addr = 32'h200; d_req_we = 1'b0; mem_req_ready = 1'b0;
    tick();
    d_req_valid = 1'b0; if_req_valid = 1'b1; if_req_addr = 32'h44;
    d_req_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #1;
      chk("t4_mem_req_valid", 32'(mem_req_valid), 32'd1);
      chk("t4_mem_addr", mem_addr, 32'h200);
      chk("t4_readys", 32'({if_req_ready, d_req_ready}), 32'd0);
      tick();
    end
    mem_req_ready = 1'b1; if_req_valid = 1'b0; d_req_valid = 1'b0;
    tick();
    chk("t4_mem_req_accepted", 32'(mem_req_valid), 32'd0);
    mem_rsp_valid = 1'b1; mem_rsp_data = 32'h0BADF00D;
    tick();
    mem_rsp_valid = 1'b0;
    chk("t4_d_rsp_valid", 32'(d_rsp_valid), 32'd1);
    chk("t4_d_rsp_data", d_rsp_data, 32'h0BADF00D);
    tick();

    // 5: no memory response -> timeout after 8 WAIT_RSP cycles
    if_req_valid = 1'b1; if_req_addr = 32'h300;
    tick();
    if_req_valid = 1'b0;
    tick();
    for (int k = 1; k <= 8; k++) begin
      chk($sformatf("t5_err_low_%0d", k), 32'(err_timeout), 32'd0);
      chk($sformatf("t5_no_rsp_%0d", k), 32'(if_rsp_valid), 32'd0);
      tick();
    end
    chk("t5_err_set", 32'(err_timeout), 32'd1);
    chk("t5_abort_rsp_valid", 32'(if_rsp_valid), 32'd1);
    chk("t5_abort_rsp_data", if_rsp_data, 32'd0);
    chk("t5_abort_d_quiet", 32'(d_rsp_valid), 32'd0);
    tick();
    chk("t5_abort_one_cycle", 32'(if_rsp_valid), 32'd0);
    mem_rsp_valid = 1'b1; mem_rsp_data = 32'h77777777;
    tick();
    mem_rsp_valid = 1'b0;
    tick();
    chk("t5_late_rsp_ignored", 32'({if_rsp_valid, d_rsp_valid}), 32'd0);
    chk("t5_err_sticky", 32'(err_timeout), 32'd1);

    // 6: reset during WAIT_RSP
    d_req_valid = 1'b1; d_req_addr = 32'h400; d_req_we = 1'b1; d_req_wdata = 32'h99;
    tick();
    d_req_valid = 1'b0; d_req_we = 1'b0; d_req_wdata = '0;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    chk("t6_mem_req_valid", 32'(mem_req_valid), 32'd0);
    chk("t6_mem_addr", mem_addr, 32'd0);
    chk("t6_mem_we", 32'(mem_we), 32'd0);
    chk("t6_mem_wdata", mem_wdata, 32'd0);
    chk("t6_err_cleared", 32'(err_timeout), 32'd0);
    chk("t6_rsp_data", if_rsp_data | d_rsp_data, 32'd0);
    chk("t6_readys", 32'({if_req_ready, d_req_ready}), 32'd0);
    mem_rsp_valid = 1'b1; mem_rsp_data = 32'h55AA55AA;
    tick();
    mem_rsp_valid = 1'b0;
    chk("t6_no_rsp_a", 32'({if_rsp_valid, d_rsp_valid}), 32'd0);
    tick();
    chk("t6_no_rsp_b", 32'({if_rsp_valid, d_rsp_valid}), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
